lsu_riscv: RTL

Load/store unit that answers the core's data-memory request port and masters a word-wide external data memory that has variable latency. It converts a core access (byte address, funct3 size code, write data) into a word-aligned access with byte enables and lane-replicated write data. On loads it returns sign- or zero-extended read data. It holds the core's stall line high until the memory handshake completes.

---
 rtl/lsu_riscv.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lsu_riscv.sv
`default_nettype none
// ============================================================================
// Module      : lsu_riscv
// Description : Load/store unit. Turns a core byte-addressed access into a
//               word-aligned memory access with byte enables and replicated
//               write data, stalls the core until the memory handshake
//               completes, and sign-/zero-extends load data.
//               Optional macro LSU_MISALIGN_CHECK_EN: when defined, misaligned
//               half/word requests are flagged and not issued to memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_riscv #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [2:0]            core_size_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [31:0]           core_wd_i,
    output logic [31:0]           core_rd_o,
    output logic                  core_stall_o,
    output logic                  core_misalign_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wd_o,
    input  logic [31:0]           mem_rd_i,
    input  logic                  mem_ready_i
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]            state_q,    state_d;
    logic                  mem_req_q,  mem_req_d;
    logic                  mem_we_q,   mem_we_d;
    logic [3:0]            mem_be_q,   mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wd_q,   mem_wd_d;
    logic [2:0]            size_q,     size_d;
    logic [1:0]            off_q,      off_d;

    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_off = core_addr_i[1:0];

    // Lane steering: byte enables and replicated store data for the request.
    // Size codes 3, 6 and 7 fall into the word branch.
    always_comb begin
        w_be = 4'b1111;
        w_wd = core_wd_i;
        case (core_size_i[1:0])
            2'b00: begin
                w_be = 4'b0001 << w_off;
                w_wd = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                w_be = w_off[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{core_wd_i[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = core_wd_i;
            end
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // Misalignment: half needs off[0]=0, word needs off=0; bytes never misalign.
    always_comb begin
        w_misalign = 1'b0;
        case (core_size_i[1:0])
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_off[0];
            default: w_misalign = (w_off != 2'b00);
        endcase
    end
`else
    // Without the check, sub-alignment offset bits are simply ignored.
    assign w_misalign = 1'b0;
`endif

    // Next-state logic for the IDLE/WAIT handshake FSM and registered mem_* outputs.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_be_d   = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        size_d     = size_q;
        off_d      = off_q;
        case (state_q)
            S_IDLE: begin
                if (core_req_i && !w_misalign) begin
                    state_d    = S_WAIT;
                    mem_req_d  = 1'b1;
                    mem_we_d   = core_we_i;
                    mem_be_d   = w_be;
                    mem_addr_d = {core_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    mem_wd_d   = w_wd;
                    size_d     = core_size_i;
                    off_d      = w_off;
                end
            end
            default: begin
                // Outputs stay frozen until memory completes the request.
                if (mem_ready_i) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_be_d  = 4'b0000;
                end
            end
        endcase
    end

    // State and memory-side registers; reset abandons any outstanding access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'b0000;
            mem_addr_q <= '0;
            mem_wd_q   <= 32'd0;
            size_q     <= 3'd0;
            off_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            size_q     <= size_d;
            off_q      <= off_d;
        end
    end

    // Load extraction uses the offset/size latched at request time.
    assign w_byte = mem_rd_i[{off_q, 3'b000} +: 8];
    assign w_half = mem_rd_i[{off_q[1], 4'b0000} +: 16];

    // Sign/zero extension: size bit 2 selects the unsigned variants.
    always_comb begin
        w_ext = mem_rd_i;
        case (size_q[1:0])
            2'b00:   w_ext = {{24{~size_q[2] & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~size_q[2] & w_half[15]}}, w_half};
            default: w_ext = mem_rd_i;
        endcase
    end

    assign core_rd_o       = ((state_q == S_WAIT) && mem_ready_i && !mem_we_q) ? w_ext : 32'd0;
    assign core_stall_o    = (state_q == S_IDLE) ? (core_req_i & ~w_misalign) : ~mem_ready_i;
    assign core_misalign_o = (state_q == S_IDLE) & core_req_i & w_misalign;

    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_be_o   = mem_be_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_wd_o   = mem_wd_q;

endmodule
`default_nettype wire
